accum_array: RTL and testbench

ACCUM_ARRAY -- requirements
Module: accum_array

---
 rtl/accum_array_pkg.sv | 24 ++
 rtl/accum_column.sv | 74 +++++++
 rtl/accum_array.sv | 107 ++++++++++
 tb/tb_accum_array.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/accum_array_pkg.sv
// Shared configuration and skewed control payload for the accumulator array.
// SYS_COLS/P_BITWIDTH mirror the systolic-array configuration this block serves.
package accum_array_pkg;

  localparam int unsigned SYS_COLS     = 4;
  localparam int unsigned P_BITWIDTH   = 16;
  localparam int unsigned ACC_W_DEF    = P_BITWIDTH + 8;
  localparam int unsigned OUT_W_DEF    = 8;
  localparam int unsigned DEPTH_DEF    = 64;

  // Control fields are sized for the largest supported shift/row widths.
  localparam int unsigned CTRL_SHIFT_W = 8;
  localparam int unsigned CTRL_ROW_W   = 16;

  typedef struct packed {
    logic                    valid;
    logic                    start;
    logic                    last;
    logic                    relu_en;
    logic [CTRL_SHIFT_W-1:0] shift;
    logic [CTRL_ROW_W-1:0]   row;
  } ctrl_t;

endpackage

// File: rtl/accum_column.sv
// One column of the accumulator array: per-row storage, accumulate, and
// requantise (arithmetic shift, optional ReLU, saturate) on the final pass.
module accum_column
  import accum_array_pkg::*;
#(
  parameter int unsigned P_W   = P_BITWIDTH,
  parameter int unsigned ACC_W = ACC_W_DEF,
  parameter int unsigned OUT_W = OUT_W_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  ctrl_t                   i_ctrl,
  input  logic signed [P_W-1:0]   i_data,
  output logic                    o_valid,
  output logic signed [OUT_W-1:0] o_data
);

  localparam int unsigned ROW_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};

  logic signed [ACC_W-1:0] r_mem [DEPTH];

  logic [ROW_W-1:0]        w_row;
  logic signed [ACC_W-1:0] w_base;
  logic signed [ACC_W-1:0] w_acc;
  logic signed [ACC_W-1:0] w_shr;
  logic signed [ACC_W-1:0] w_relu;
  logic signed [OUT_W-1:0] w_q;
  logic                    w_unused_row;

  // Row field is wider than the memory index when DEPTH is small.
  assign w_unused_row = &{1'b0, i_ctrl.row};

  // Accumulate (modulo 2^ACC_W) and requantise the new value.
  always_comb begin
    w_row  = i_ctrl.row[ROW_W-1:0];
    w_base = i_ctrl.start ? '0 : r_mem[w_row];
    w_acc  = w_base + ACC_W'(i_data);
    w_shr  = w_acc >>> i_ctrl.shift;
    w_relu = (i_ctrl.relu_en && w_shr[ACC_W-1]) ? '0 : w_shr;
    if (w_relu > SAT_MAX) begin
      w_q = SAT_MAX[OUT_W-1:0];
    end else if (w_relu < SAT_MIN) begin
      w_q = SAT_MIN[OUT_W-1:0];
    end else begin
      w_q = w_relu[OUT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && i_ctrl.valid) begin
      r_mem[w_row] <= w_acc;
    end
  end

  // o_data holds its last value between final-pass rows.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid <= 1'b0;
      o_data  <= '0;
    end else begin
      o_valid <= i_ctrl.valid && i_ctrl.last;
      if (i_ctrl.valid && i_ctrl.last) begin
        o_data <= w_q;
      end
    end
  end

endmodule

// File: rtl/accum_array.sv
// Output accumulator for a systolic array: skews row control across columns
// so each column sees its control exactly as its diagonal data arrives.
module accum_array
  import accum_array_pkg::*;
#(
  parameter int unsigned NUM_COLS = SYS_COLS,
  parameter int unsigned P_W      = P_BITWIDTH,
  parameter int unsigned ACC_W    = ACC_W_DEF,
  parameter int unsigned OUT_W    = OUT_W_DEF,
  parameter int unsigned DEPTH    = DEPTH_DEF
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_valid,
  input  logic                                 start,
  input  logic                                 last,
  input  logic                                 relu_en,
  input  logic [$clog2(ACC_W)-1:0]             shift,
  input  logic signed [NUM_COLS-1:0][P_W-1:0]  i_data,
  output logic [NUM_COLS-1:0]                  o_valid,
  output logic signed [NUM_COLS-1:0][OUT_W-1:0] o_data,
  output logic                                 done,
  output logic                                 overflow
);

  localparam int unsigned ROW_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (NUM_COLS < 2 || ACC_W < P_W || OUT_W > ACC_W ||
      ROW_W > CTRL_ROW_W || $clog2(ACC_W) > CTRL_SHIFT_W) begin : g_bad_cfg
    $error("accum_array: unsupported parameter set");
  end

  logic [ROW_W-1:0] r_row;
  logic             r_prev_valid;
  logic             r_done;
  logic             r_overflow;
  ctrl_t            r_skew [NUM_COLS-1];
  ctrl_t            w_ctrl [NUM_COLS];
  logic             w_row_last;

  assign w_row_last = (r_row == ROW_W'(DEPTH - 1));

  // Column 0 takes control straight from the ports; others from the skew chain.
  always_comb begin
    for (int unsigned c = 0; c < NUM_COLS; c++) begin
      w_ctrl[c] = '0;
    end
    w_ctrl[0].valid   = in_valid;
    w_ctrl[0].start   = start;
    w_ctrl[0].last    = last;
    w_ctrl[0].relu_en = relu_en;
    w_ctrl[0].shift   = CTRL_SHIFT_W'(shift);
    w_ctrl[0].row     = CTRL_ROW_W'(r_row);
    for (int unsigned c = 1; c < NUM_COLS; c++) begin
      w_ctrl[c] = r_skew[c-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_row        <= '0;
      r_prev_valid <= 1'b0;
      r_done       <= 1'b0;
      r_overflow   <= 1'b0;
      for (int unsigned c = 0; c < NUM_COLS - 1; c++) begin
        r_skew[c] <= '0;
      end
    end else begin
      r_prev_valid <= in_valid;
      if (!in_valid || w_row_last) begin
        r_row <= '0;
      end else begin
        r_row <= r_row + ROW_W'(1);
      end
      // Row 0 reached again inside one burst means entries are being reused.
      if (in_valid && r_prev_valid && (r_row == '0)) begin
        r_overflow <= 1'b1;
      end
      // Final column busy now and idle next cycle: the pass has drained.
      r_done <= w_ctrl[NUM_COLS-1].valid && !w_ctrl[NUM_COLS-2].valid;
      r_skew[0] <= w_ctrl[0];
      for (int unsigned c = 1; c < NUM_COLS - 1; c++) begin
        r_skew[c] <= r_skew[c-1];
      end
    end
  end

  assign done     = r_done;
  assign overflow = r_overflow;

  for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
    accum_column #(
      .P_W   (P_W),
      .ACC_W (ACC_W),
      .OUT_W (OUT_W),
      .DEPTH (DEPTH)
    ) u_col (
      .clk     (clk),
      .rst     (rst),
      .i_ctrl  (w_ctrl[c]),
      .i_data  (i_data[c]),
      .o_valid (o_valid[c]),
      .o_data  (o_data[c])
    );
  end

endmodule

// File: tb/tb_accum_array.sv
// Directed bench for accum_array with 4 columns, 4-deep storage, 8-bit output.
module tb_accum_array;

  localparam int unsigned NC = 4;

  logic                         clk;
  logic                         rst;
  logic                         in_valid;
  logic                         start;
  logic                         last;
  logic                         relu_en;
  logic [4:0]                   shift;
  logic signed [NC-1:0][15:0]   i_data;
  logic [NC-1:0]                o_valid;
  logic signed [NC-1:0][7:0]    o_data;
  logic                         done;
  logic                         overflow;

  accum_array #(
    .NUM_COLS (NC),
    .P_W      (16),
    .ACC_W    (24),
    .OUT_W    (8),
    .DEPTH    (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .start    (start),
    .last     (last),
    .relu_en  (relu_en),
    .shift    (shift),
    .i_data   (i_data),
    .o_valid  (o_valid),
    .o_data   (o_data),
    .done     (done),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  int hist [0:3][0:3];
  int mon_val [0:3][0:7];
  int mon_cnt [0:3];
  int first_cyc [0:3];
  int done_cnt;
  int t0;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Captures every result row and done pulse between clock edges.
  always @(negedge clk) begin
    for (int c = 0; c < NC; c++) begin
      if (o_valid[c]) begin
        if (mon_cnt[c] < 8) mon_val[c][mon_cnt[c]] = int'(signed'(o_data[c]));
        if (first_cyc[c] < 0) first_cyc[c] = cyc;
        mon_cnt[c] = mon_cnt[c] + 1;
      end
    end
    if (done) done_cnt = done_cnt + 1;
  end

  task automatic mon_clear();
    for (int c = 0; c < NC; c++) begin
      mon_cnt[c]   = 0;
      first_cyc[c] = -1;
    end
    done_cnt = 0;
  endtask

  // Apply one row cycle; column c sees the data of the row issued c cycles ago.
  task automatic step(input bit v, input bit st, input bit ls, input bit rl,
                      input int sh, input int d0, input int d1, input int d2,
                      input int d3);
    int dv [0:3];
    dv = '{d0, d1, d2, d3};
    for (int c = NC - 1; c > 0; c--) hist[c] = hist[c-1];
    for (int c = 0; c < NC; c++) hist[0][c] = v ? dv[c] : 0;
    for (int c = 0; c < NC; c++) i_data[c] = 16'(hist[c][c]);
    in_valid = v;
    start    = st;
    last     = ls;
    relu_en  = rl;
    shift    = 5'(sh);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    start    = 1'b0;
    last     = 1'b0;
    relu_en  = 1'b0;
    shift    = '0;
    i_data   = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) hist[r][c] = 0;
    mon_clear();
    repeat (2) @(posedge clk);
    #1;
    check("rst_o_valid", int'(o_valid), 0);
    check("rst_o_data", int'(o_data), 0);
    check("rst_done", int'(done), 0);
    check("rst_overflow", int'(overflow), 0);
    rst = 1'b0;
    idle(2);

    // Three 2-row passes of 10s: start, middle, last.
    mon_clear();
    repeat (2) step(1'b1, 1'b1, 1'b0, 1'b0, 0, 10, 10, 10, 10);
    idle(6);
    repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0, 0, 10, 10, 10, 10);
    idle(6);
    check("mid_pass_no_valid", mon_cnt[0] + mon_cnt[1] + mon_cnt[2] + mon_cnt[3], 0);
    mon_clear();
    t0 = cyc;
    repeat (2) step(1'b1, 1'b0, 1'b1, 1'b0, 0, 10, 10, 10, 10);
    idle(6);
    for (int c = 0; c < NC; c++) begin
      check($sformatf("p3_first_cyc_c%0d", c), first_cyc[c], t0 + c + 1);
      check($sformatf("p3_count_c%0d", c), mon_cnt[c], 2);
      check($sformatf("p3_row0_c%0d", c), mon_val[c][0], 30);
      check($sformatf("p3_row1_c%0d", c), mon_val[c][1], 30);
    end
    check("p3_done_once", done_cnt, 1);
    check("p3_overflow", int'(overflow), 0);

    // Single pass of -50 with and without ReLU.
    mon_clear();
    step(1'b1, 1'b1, 1'b1, 1'b1, 0, -50, -50, -50, -50);
    idle(6);
    for (int c = 0; c < NC; c++) check($sformatf("relu_on_c%0d", c), mon_val[c][0], 0);
    mon_clear();
    step(1'b1, 1'b1, 1'b1, 1'b0, 0, -50, -50, -50, -50);
    idle(6);
    for (int c = 0; c < NC; c++) check($sformatf("relu_off_c%0d", c), mon_val[c][0], -50);

    // Shift then saturate at both rails.
    mon_clear();
    step(1'b1, 1'b1, 1'b1, 1'b0, 2, 1000, 1000, 1000, 1000);
    idle(6);
    for (int c = 0; c < NC; c++) check($sformatf("sat_hi_c%0d", c), mon_val[c][0], 127);
    mon_clear();
    step(1'b1, 1'b1, 1'b1, 1'b0, 2, -1000, -1000, -1000, -1000);
    idle(6);
    for (int c = 0; c < NC; c++) check($sformatf("sat_lo_c%0d", c), mon_val[c][0], -128);
    check("pre_burst_overflow", int'(overflow), 0);

    // Five-row burst into four entries.
    repeat (5) step(1'b1, 1'b1, 1'b0, 1'b0, 0, 1, 1, 1, 1);
    idle(6);
    check("burst_overflow", int'(overflow), 1);
    idle(3);
    check("overflow_sticky", int'(overflow), 1);

    // Back-to-back passes with a single idle cycle between them.
    mon_clear();
    step(1'b1, 1'b1, 1'b0, 1'b0, 0, 5, 15, 25, 35);
    step(1'b1, 1'b1, 1'b0, 1'b0, 0, 6, 16, 26, 36);
    idle(1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 0, -4, -1, 2, 5);
    step(1'b1, 1'b0, 1'b1, 1'b0, 0, -6, -3, 0, 3);
    idle(6);
    for (int c = 0; c < NC; c++) begin
      check($sformatf("b2b_row0_c%0d", c), mon_val[c][0], 13 * c + 1);
      check($sformatf("b2b_row1_c%0d", c), mon_val[c][1], 13 * c);
    end
    check("b2b_overflow_kept", int'(overflow), 1);

    // Reset in the middle of a final pass drops everything in flight.
    step(1'b1, 1'b1, 1'b1, 1'b0, 0, 7, 7, 7, 7);
    step(1'b1, 1'b1, 1'b1, 1'b0, 0, 9, 9, 9, 9);
    rst = 1'b1;
    idle(1);
    check("midrst_o_valid", int'(o_valid), 0);
    check("midrst_o_data", int'(o_data), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_overflow", int'(overflow), 0);
    rst = 1'b0;
    mon_clear();
    idle(8);
    check("midrst_late_valid", mon_cnt[0] + mon_cnt[1] + mon_cnt[2] + mon_cnt[3], 0);
    check("midrst_late_done", done_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
